// File: rtl/seq_add_pkg.sv
// Shared definitions for the chunk-serial adder controller.
//   state_t     : controller FSM states (IDLE / BUSY / DONE)
//   CHUNK_W     : width of the single adder slice, in bits
//   num_chunks(): number of CHUNK_W-bit passes needed for a WIDTH-bit
//                 operation plus its carry-out bit
package seq_add_pkg;

    localparam int CHUNK_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil((width + 1) / CHUNK_W): the extra bit leaves room for the carry-out.
    function automatic int num_chunks(input int width);
        return (width + CHUNK_W) / CHUNK_W;
    endfunction

endpackage

// File: rtl/cla_6bit.sv
// Single CHUNK_W-bit carry-lookahead adder slice.
//   a, b   : chunk operands
//   c_in   : carry into bit 0
//   sum    : chunk sum
//   c_out  : carry out of the top bit
module cla_6bit
    import seq_add_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               c_in,
    output logic [CHUNK_W-1:0] sum,
    output logic               c_out
);

    logic [CHUNK_W-1:0] gen;
    logic [CHUNK_W-1:0] prop;
    logic [CHUNK_W:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Carry into bit i+1, flattened: g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
    // Every carry is a function of g/p/c_in only, never of a lower carry.
    function automatic logic lookahead(input logic [CHUNK_W-1:0] g,
                                       input logic [CHUNK_W-1:0] p,
                                       input logic               cin,
                                       input int                 i);
        logic acc;
        logic pp;
        acc = g[i];
        pp  = p[i];
        for (int j = i - 1; j >= 0; j--) begin
            acc = acc | (pp & g[j]);
            pp  = pp & p[j];
        end
        return acc | (pp & cin);
    endfunction

    assign carry[0] = c_in;

    for (genvar i = 0; i < CHUNK_W; i++) begin : g_carry
        assign carry[i+1] = lookahead(gen, prop, c_in, i);
    end

    assign sum   = prop ^ carry[CHUNK_W-1:0];
    assign c_out = carry[CHUNK_W];

endmodule

// File: rtl/seq_add_ctrl.sv
// Chunk-serial add/subtract controller.
// Operands are zero-padded to NUM_CHUNKS*CHUNK_W bits and summed one chunk
// per cycle through a single cla_6bit slice; the slice carry is kept in a
// register between passes. Subtract is A + ~B + 1 (B inverted at capture,
// carry register seeded with 1).
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_valid / o_ready   : request handshake (accepted only in IDLE)
//   i_a, i_b, i_sub     : operands and operation select
//   i_flush             : synchronous abort, highest priority
//   o_valid / i_ready   : result handshake (held in DONE until taken)
//   o_result, o_carry   : sum bits [WIDTH-1:0] and bit WIDTH (1 = no borrow)
//   o_overflow          : two's-complement signed overflow
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH);
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
    localparam int CNT_W      = $clog2(NUM_CHUNKS);
    localparam int MSB_CH     = (WIDTH - 1) / CHUNK_W;
    localparam int MSB_BIT    = (WIDTH - 1) % CHUNK_W;

    state_t                               state;
    logic [CNT_W-1:0]                     cnt;
    logic                                 carry;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   a_reg;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   b_reg;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   sum_reg;

    logic [CHUNK_W-1:0]                   slice_sum;
    logic                                 slice_cout;
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]   sum_next;
    logic [PAD_W-1:0]                     sum_flat;
    logic [WIDTH-1:0]                     b_eff;
    logic                                 last;
    logic                                 ovf_next;

    cla_6bit u_cla (
        .a     (a_reg[cnt]),
        .b     (b_reg[cnt]),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // Partial sum with the current chunk merged in; on the last pass this is
    // the complete padded sum, so the result flags can be registered straight
    // from it on the DONE transition.
    always_comb begin
        sum_next      = sum_reg;
        sum_next[cnt] = slice_sum;
    end

    assign sum_flat = sum_next;
    assign b_eff    = i_sub ? ~i_b : i_b;
    assign last     = (cnt == CNT_W'(NUM_CHUNKS - 1));
    assign ovf_next = (a_reg[MSB_CH][MSB_BIT] == b_reg[MSB_CH][MSB_BIT]) &&
                      (sum_flat[WIDTH-1] != a_reg[MSB_CH][MSB_BIT]);

    // Padding bits above the carry position never leave the block.
    if (PAD_W > WIDTH + 1) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^sum_flat[PAD_W-1:WIDTH+1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_flush) begin
            state      <= IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_reg      <= PAD_W'(i_a);
                        b_reg      <= PAD_W'(b_eff);
                        sum_reg    <= '0;
                        carry      <= i_sub;
                        cnt        <= '0;
                        o_ready    <= 1'b0;
                        o_result   <= '0;
                        o_carry    <= 1'b0;
                        o_overflow <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    sum_reg <= sum_next;
                    carry   <= slice_cout;
                    if (last) begin
                        cnt        <= '0;
                        o_valid    <= 1'b1;
                        o_result   <= sum_flat[WIDTH-1:0];
                        o_carry    <= sum_flat[WIDTH];
                        o_overflow <= ovf_next;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE only; a request seen on this edge waits
                    // for the following one.
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed bench for seq_add_ctrl (WIDTH = 32): reset values, add/sub
// corner vectors, result backpressure, flush and mid-operation reset.
module tb_seq_add_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_sub;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_carry;
    logic        o_overflow;

    int n_checks = 0;
    int n_fails  = 0;

    seq_add_ctrl #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_sub      (i_sub),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_carry    (o_carry),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  o_ready,    1);
        check({tag, "_valid"},  o_valid,    0);
        check({tag, "_result"}, o_result,   0);
        check({tag, "_carry"},  o_carry,    0);
        check({tag, "_ovf"},    o_overflow, 0);
    endtask

    // Present one request across a single rising edge (the accept edge).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Called 1 time unit after an accept edge: counts edges to o_valid,
    // checks the result, then completes the handshake.
    task automatic wait_done(input string tag, input logic [31:0] er,
                             input logic ec, input logic ev);
        int n;
        n = 0;
        check({tag, "_busy_ready"}, o_ready, 0);
        do begin
            @(posedge i_clk);
            #1;
            n++;
        end while (!o_valid && n < 20);
        check({tag, "_latency"}, n,          6);
        check({tag, "_result"},  o_result,   er);
        check({tag, "_carry"},   o_carry,    ec);
        check({tag, "_ovf"},     o_overflow, ev);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_hs_valid"}, o_valid, 0);
        check({tag, "_hs_ready"}, o_ready, 1);
    endtask

    initial begin
        bit saw_valid;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b0;

        #23;
        check_reset_vals("rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;

        // First accept on the first rising edge after reset release.
        start_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        wait_done("add_wrap", 32'h0000_0000, 1'b1, 1'b0);

        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("add_ovf", 32'h8000_0000, 1'b0, 1'b1);

        start_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        wait_done("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);

        start_op(32'd5, 32'd7, 1'b1);
        wait_done("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0);

        start_op(32'd7, 32'd5, 1'b1);
        wait_done("sub_7_5", 32'h0000_0002, 1'b1, 1'b0);

        start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
        wait_done("add_mix", 32'h2222_2221, 1'b0, 1'b0);

        // Backpressure: result held for 3 cycles while a new request is ignored.
        start_op(32'd3, 32'd4, 1'b0);
        for (int k = 0; k < 20 && !o_valid; k++) begin
            @(posedge i_clk);
            #1;
        end
        check("bp_valid_up", o_valid, 1);
        i_a     = 32'd10;
        i_b     = 32'd20;
        i_sub   = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            check("bp_hold_valid",  o_valid,  1);
            check("bp_hold_result", o_result, 32'd7);
            check("bp_hold_ready",  o_ready,  0);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check("bp_hs_valid", o_valid, 0);
        check("bp_hs_ready", o_ready, 1);
        // i_valid still high: accepted on this edge, not the handshake edge.
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        wait_done("bp_next", 32'd30, 1'b0, 1'b0);

        // Flush while cnt = 3.
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush_ready", o_ready, 1);
        check("flush_valid", o_valid, 0);
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge i_clk);
            #1;
            if (o_valid) saw_valid = 1'b1;
        end
        check("flush_no_valid", saw_valid, 0);

        // Flush coincident with a request in IDLE: no accept.
        i_a     = 32'd1;
        i_b     = 32'd1;
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        check("flush_idle_ready", o_ready, 1);
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge i_clk);
            #1;
            if (o_valid) saw_valid = 1'b1;
        end
        check("flush_idle_no_valid", saw_valid, 0);

        // Asynchronous reset mid-BUSY, then a clean operation.
        start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_busy");
        #1;
        i_rst_n = 1'b1;
        #1;
        start_op(32'd100, 32'd23, 1'b0);
        wait_done("after_rst", 32'd123, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/seq_add_ctrl.md
SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal range 6..47.
REQ-002 SHALL derive constant NUM_CHUNKS = ceil((WIDTH+1)/6), default 6, the number of 6-bit passes per operation.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  request valid.
REQ-007 o_ready  output  1  controller can accept a request.
REQ-008 i_a, i_b  input  WIDTH  operands.
REQ-009 i_sub  input  1  1 = i_a - i_b, 0 = i_a + i_b.
REQ-010 i_flush  input  1  synchronous abort of any operation.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  consumer accepts result.
REQ-013 o_result  output  WIDTH  sum or difference.
REQ-014 o_carry  output  1  carry out of bit WIDTH-1; for subtract, 1 = no borrow.
REQ-015 o_overflow  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-017 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-018 Accept occurs on an edge with IDLE && i_valid && !i_flush: capture i_a; capture i_b (inverted when i_sub=1); zero-pad both to 6*NUM_CHUNKS bits; carry register <= i_sub; chunk counter <= 0; next state = BUSY.
REQ-019 Each BUSY cycle SHALL add one chunk: chunk[cnt] of A, chunk[cnt] of B and the carry register feed the single 6-bit adder; the sum is written into result chunk cnt; the carry register takes C_out; cnt increments.
REQ-020 The edge with cnt = NUM_CHUNKS-1 SHALL move the FSM to DONE; o_valid therefore rises exactly NUM_CHUNKS edges after the accept edge (6 for the default).
REQ-021 o_result SHALL equal padded-sum bits [WIDTH-1:0]; o_carry SHALL equal padded-sum bit WIDTH.
REQ-022 o_overflow SHALL be (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the possibly inverted operand.
REQ-023 In DONE, o_result, o_carry and o_overflow SHALL hold stable until o_valid && i_ready; on that edge the FSM returns to IDLE and o_ready rises the next cycle (no same-cycle reaccept).
REQ-024 i_flush SHALL take priority over everything else: any state goes to IDLE on the next edge, the result is discarded, no o_valid is produced, and an i_valid in the same cycle is not accepted.
REQ-025 i_valid and operand changes outside IDLE SHALL be ignored.
REQ-026 Outputs SHALL be registered; o_result SHALL read 0 and shall not be used until o_valid.

Reset
REQ-027 On i_rst_n low, asynchronously: state = IDLE, cnt = 0, carry = 0, operand/result registers = 0.
REQ-028 Reset values: o_ready = 1, o_valid = 0, o_result = 0, o_carry = 0, o_overflow = 0.
REQ-029 Reset mid-BUSY or mid-DONE SHALL drop the in-flight operation silently.
REQ-030 The first accept is possible on the first rising edge after deassertion.

Structure
REQ-031 Shared package seq_add_pkg SHALL hold the state enum (IDLE/BUSY/DONE), CHUNK_W = 6 and the NUM_CHUNKS function.
REQ-032 SHALL instantiate exactly one cla_6bit as the sole adder datapath; the controller itself contains no other adder apart from the chunk counter.

Verification
REQ-033 Add 0x0000_0001 + 0xFFFF_FFFF -> o_valid 6 edges after accept; result 0x0000_0000, carry 1, overflow 0.
REQ-034 Add 0x7FFF_FFFF + 0x0000_0001 -> result 0x8000_0000, carry 0, overflow 1; sub 0x8000_0000 - 1 -> result 0x7FFF_FFFF, overflow 1.
REQ-035 Sub 5 - 7 -> result 0xFFFF_FFFE, carry 0; sub 7 - 5 -> result 0x0000_0002, carry 1; overflow 0 in both cases.
REQ-036 Backpressure: hold i_ready = 0 for 3 cycles in DONE -> o_valid and o_result stable, o_ready = 0, and a new i_valid is ignored; the request is accepted only after the handshake completes.
REQ-037 Flush at cnt = 3 -> IDLE next edge, o_valid never asserts; a flush coincident with i_valid in IDLE -> no accept.
REQ-038 Drive i_rst_n low mid-BUSY -> immediate IDLE with outputs at reset values; the next request completes with a correct result.
